// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory req/ack port and the
// valid/ready instruction stream toward decode.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_data, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_data, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word read
// at a time and buffers returned words with their PCs in a small circular queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  fetch_unit_if.master bus
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e            state_q;
  logic [31:0]       fpc_q;
  logic [31:0]       addr_q;
  logic              memReq_q;
  logic [PTRW-1:0]   wrPtr_q;
  logic [PTRW-1:0]   rdPtr_q;
  logic [CNTW-1:0]   count_q;
  logic [CNTW-1:0]   count_d;
  logic [31:0]       instrMem [DEPTH];
  logic [31:0]       pcMem    [DEPTH];

  logic [31:0] target;
  logic [31:0] ackPc;
  logic        ackTaken;
  logic        push;
  logic        pop;
  logic        space;
  logic        go;

  // A new request is only allowed if the queue can still hold its word after
  // this cycle's push/pop settle.
  always_comb begin
    target   = redirect_pc_i & 32'hFFFF_FFFC;
    ackTaken = (state_q != IDLE) && bus.mem_ack;
    push     = (state_q == REQ) && ackTaken && !redirect_i;
    pop      = (count_q != '0) && bus.instr_ready;
    count_d  = count_q;
    if (redirect_i) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
    space = count_d < CNTW'(DEPTH);
    go    = start_i && space;
    if (redirect_i)
      ackPc = target;
    else if (state_q == REQ)
      ackPc = fpc_q + 32'd4;
    else
      ackPc = fpc_q;
  end

  // addr_q is frozen while a request is outstanding so a redirect never
  // disturbs the address the memory is currently serving.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      memReq_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_i) begin
            fpc_q  <= target;
            addr_q <= target;
          end else if (go) begin
            state_q  <= REQ;
            memReq_q <= 1'b1;
          end
        end
        REQ, DISCARD: begin
          if (ackTaken) begin
            fpc_q    <= ackPc;
            addr_q   <= ackPc;
            state_q  <= go ? REQ : IDLE;
            memReq_q <= go;
          end else if (redirect_i) begin
            fpc_q   <= target;
            state_q <= DISCARD;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      count_q <= count_d;
      if (redirect_i) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PTRW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + PTRW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instrMem[wrPtr_q] <= bus.mem_data;
      pcMem[wrPtr_q]    <= addr_q;
    end
  end

  // Head outputs are forced to zero when empty so they never expose stale entries.
  assign bus.mem_req     = memReq_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = (count_q != '0) ? instrMem[rdPtr_q] : 32'h0;
  assign bus.instr_pc    = (count_q != '0) ? pcMem[rdPtr_q]    : 32'h0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the single-cycle datapath's decode/register-read logic. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Fetched words and their PCs are buffered in a small queue, which presents them to decode with a valid/ready handshake. It also handles branch/jump redirects, discarding any stale in-flight or buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- DEPTH, 2, instruction queue entries; power of two, ≥2
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  fetch enable; while low no new request is issued
- redirect_i  in  1  one-cycle pulse: flush and refetch from redirect_pc_i
- redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0
- mem_req_o  out  1  read request to instruction memory
- mem_addr_o  out  32  request address (fetch PC), word aligned
- mem_ack_i  in  1  memory response valid; completes the current request
- mem_data_i  in  32  instruction word, valid when mem_ack_i=1
- instr_valid_o  out  1  queue head valid
- instr_o  out  32  queue head instruction
- instr_pc_o  out  32  PC of queue head
- instr_ready_i  in  1  decode accepts head when instr_valid_o && instr_ready_i

## Operation
- States: IDLE (no request), REQ (request outstanding, data kept), DISCARD (request outstanding, data dropped).
- mem_req_o=1 exactly in REQ and DISCARD; mem_addr_o held stable until mem_ack_i. At most one outstanding request.
- Ack may arrive in the first request cycle (zero-wait) or any later cycle.
- Space condition: count_next + 1 ≤ DEPTH, where count_next is the queue occupancy after this cycle's push/pop.
- IDLE → REQ: start_i=1 and space and no redirect.
- REQ, ack, no redirect: push {mem_data_i, fpc}; fpc += 4 (mod 2^32, wraps silently). Stay in REQ if start_i && space, else → IDLE.
- REQ, no ack, redirect: fpc ← redirect target; → DISCARD.
- REQ, ack, redirect: data dropped, no push; fpc ← target; → REQ if start_i else IDLE.
- DISCARD, ack: data dropped; → REQ if start_i && space, else IDLE.
- DISCARD, redirect: fpc updated to the newest target; stays in DISCARD.
- Redirect in IDLE: fpc ← target; → IDLE. A request may be issued from the following cycle.
- Redirect clears the queue (count ← 0) in the same edge. A pop in the redirect cycle is counted as taken by decode but has no further effect.
- start_i low mid-request: the outstanding request completes and is pushed normally; no further requests follow.
- Queue: circular buffer, pointers wrap mod DEPTH. Simultaneous push and pop when full is impossible by the space rule. Push and pop in the same cycle leave count unchanged.

## Timing
- Reset (async): state=IDLE, fpc=RESET_PC, count=0, pointers=0. Outputs: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- instr_valid_o, instr_o and instr_pc_o are driven from registered queue state only. A word acked in cycle N is visible at the head in cycle N+1 if the queue was empty.
- First request asserts the cycle after start_i is sampled high in IDLE.
- Zero-wait memory and decode always ready: sustained one instruction per cycle.
- Redirect-to-first-valid latency with zero-wait memory: request in cycle R+1, instr_valid_o in cycle R+2.
- Reset asserted mid-request: mem_req_o drops immediately (async). Any late ack after reset release in IDLE is ignored.

## Test plan
- Reset then start_i=1, zero-wait memory returning addr, ready=1 → instr_pc_o sequence 0,4,8,… one per cycle with instr_o = instr_pc_o.
- ready=0, DEPTH=2 → exactly 2 words buffered, then mem_req_o=0. Raise ready → heads PC 0 then 4, fetch resumes at 8.
- 3-cycle memory latency, redirect to 0x100 in the second wait cycle → acked word for the old PC dropped; next request addr 0x100; first valid instr_pc_o=0x100.
- Redirect to 0x203 in the same cycle as an ack → no push; queue empty next cycle; next mem_addr_o=0x200.
- Two redirects (0x40, then 0x80) during one DISCARD → only 0x80 fetched afterwards.
- Assert rst_i mid-request with 2 words buffered → all outputs at reset values the same cycle; after release and start_i, fetch restarts at RESET_PC.
